// File: rtl/elevator_pkg.sv
// Shared types and floor helpers for the three-floor elevator controller.
package elevator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DOOR_OPEN,
      ST_MOVE_UP,
      ST_MOVE_DOWN,
      ST_SOS_HOLD
   } state_t;

   typedef enum logic {
      DIR_UP,
      DIR_DOWN
   } dir_t;

   typedef logic [1:0] floor_t;

   localparam floor_t F1 = 2'd0;
   localparam floor_t F2 = 2'd1;
   localparam floor_t F3 = 2'd2;

   localparam int TIMER_W = 4;
   localparam int COUNT_W = 4;

   function automatic logic [2:0] floor_onehot(input floor_t f);
      return 3'b001 << f;
   endfunction

   function automatic logic [2:0] above_mask(input floor_t f);
      case (f)
         F1:      return 3'b110;
         F2:      return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] below_mask(input floor_t f);
      case (f)
         F3:      return 3'b011;
         F2:      return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for a raw board input, with a one-cycle edge pulse
// on the selected transition of the synchronized level.
module sync_edge #(
   parameter logic IDLE_VAL = 1'b0,
   parameter logic FALLING  = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic pulse
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= IDLE_VAL;
         sync <= IDLE_VAL;
         prev <= IDLE_VAL;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   assign level = sync;
   assign pulse = FALLING ? (prev & ~sync) : (sync & ~prev);

endmodule

// File: rtl/elevator_controller.sv
// Three-floor elevator: latches calls, moves one floor at a time, times the door,
// enforces a passenger weight limit and an SOS hold.
//
// state        | meaning
// ST_IDLE      | stopped, door closed, choosing the next move
// ST_DOOR_OPEN | stopped, door open, door timer running (held while overweight)
// ST_MOVE_UP   | travelling up one floor segment
// ST_MOVE_DOWN | travelling down one floor segment
// ST_SOS_HOLD  | SOS stop, door open, calls ignored and cleared
module elevator_controller
   import elevator_pkg::*;
#(
   parameter int MAX_PEOPLE  = 6,
   parameter int FLOOR_TICKS = 4,
   parameter int DOOR_TICKS  = 4
) (
   input  logic clk_50,
   input  logic rst_n,
   input  logic button1,
   input  logic button2,
   input  logic button3,
   input  logic sos_flip,
   input  logic weight_flip,
   input  logic weight_flip_reset,
   output logic led1,
   output logic led2,
   output logic led3,
   output logic floor1,
   output logic floor2,
   output logic floor3,
   output logic door,
   output logic moving,
   output logic sos_mode,
   output logic weight_limit_exceeded
);

   localparam logic [TIMER_W-1:0] FLOOR_LOAD = TIMER_W'(FLOOR_TICKS - 1);
   localparam logic [TIMER_W-1:0] DOOR_LOAD  = TIMER_W'(DOOR_TICKS - 1);
   localparam logic [COUNT_W-1:0] MAX_CNT    = COUNT_W'(MAX_PEOPLE);

   logic [2:0]         btn_raw;
   logic [2:0]         call;
   logic [2:0]         btn_level_unused;
   logic               enter_pulse;
   logic               clear_pulse;
   logic               enter_level_unused;
   logic               clear_level_unused;
   logic               sos_sync;
   logic               sos_pulse_unused;

   state_t             state, state_next;
   floor_t             car_floor, floor_next;
   dir_t               dir, dir_next;
   logic [TIMER_W-1:0] timer, timer_next;
   logic [2:0]         req, req_next;
   logic [COUNT_W-1:0] count;

   logic               overweight;
   logic [2:0]         new_calls;
   logic [2:0]         here_mask;
   floor_t             arrive_floor;
   logic [2:0]         arrive_mask;
   logic               go_up;
   logic               go_down;

   assign btn_raw = {button3, button2, button1};

   for (genvar i = 0; i < 3; i++) begin : g_btn
      sync_edge #(.IDLE_VAL(1'b1), .FALLING(1'b1)) u_btn (
         .clk   (clk_50),
         .rst_n (rst_n),
         .din   (btn_raw[i]),
         .level (btn_level_unused[i]),
         .pulse (call[i])
      );
   end

   sync_edge #(.IDLE_VAL(1'b0), .FALLING(1'b0)) u_enter (
      .clk   (clk_50),
      .rst_n (rst_n),
      .din   (weight_flip),
      .level (enter_level_unused),
      .pulse (enter_pulse)
   );

   sync_edge #(.IDLE_VAL(1'b0), .FALLING(1'b0)) u_clear (
      .clk   (clk_50),
      .rst_n (rst_n),
      .din   (weight_flip_reset),
      .level (clear_level_unused),
      .pulse (clear_pulse)
   );

   sync_edge #(.IDLE_VAL(1'b0), .FALLING(1'b0)) u_sos (
      .clk   (clk_50),
      .rst_n (rst_n),
      .din   (sos_flip),
      .level (sos_sync),
      .pulse (sos_pulse_unused)
   );

   // Clearing the count beats a simultaneous enter; count saturates at all-ones.
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear_pulse) begin
         count <= '0;
      end else if (enter_pulse && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign overweight   = (count > MAX_CNT);
   assign new_calls    = sos_sync ? 3'b000 : call;
   assign here_mask    = floor_onehot(car_floor);
   assign arrive_floor = (state == ST_MOVE_DOWN) ? (car_floor - 2'd1) : (car_floor + 2'd1);
   assign arrive_mask  = floor_onehot(arrive_floor);

   // Keep heading the same way while calls lie ahead, otherwise reverse.
   assign go_up   = (|(req & above_mask(car_floor))) &&
                    ((dir == DIR_UP) || !(|(req & below_mask(car_floor))));
   assign go_down = |(req & below_mask(car_floor));

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         car_floor <= F1;
         dir       <= DIR_UP;
         timer     <= '0;
         req       <= '0;
      end else begin
         state     <= state_next;
         car_floor <= floor_next;
         dir       <= dir_next;
         timer     <= timer_next;
         req       <= req_next;
      end
   end

   always_comb begin
      state_next = state;
      floor_next = car_floor;
      dir_next   = dir;
      timer_next = timer;
      req_next   = req | new_calls;

      case (state)
         ST_IDLE: begin
            if (sos_sync) begin
               state_next = ST_SOS_HOLD;
               req_next   = '0;
            end else if (overweight || (|(req_next & here_mask))) begin
               state_next = ST_DOOR_OPEN;
               timer_next = DOOR_LOAD;
               req_next   = req_next & ~here_mask;
            end else if (go_up) begin
               state_next = ST_MOVE_UP;
               dir_next   = DIR_UP;
               timer_next = FLOOR_LOAD;
            end else if (go_down) begin
               state_next = ST_MOVE_DOWN;
               dir_next   = DIR_DOWN;
               timer_next = FLOOR_LOAD;
            end
         end

         ST_DOOR_OPEN: begin
            req_next = req_next & ~here_mask;
            if (sos_sync) begin
               state_next = ST_SOS_HOLD;
               req_next   = '0;
            end else if (overweight || (|(new_calls & here_mask))) begin
               timer_next = DOOR_LOAD;
            end else if (timer == '0) begin
               state_next = ST_IDLE;
            end else begin
               timer_next = timer - 1'b1;
            end
         end

         ST_MOVE_UP, ST_MOVE_DOWN: begin
            if (timer != '0) begin
               timer_next = timer - 1'b1;
            end else begin
               floor_next = arrive_floor;
               if (arrive_floor == F3) begin
                  dir_next = DIR_DOWN;
               end else if (arrive_floor == F1) begin
                  dir_next = DIR_UP;
               end
               if (sos_sync) begin
                  state_next = ST_SOS_HOLD;
                  req_next   = '0;
               end else if (|(req_next & arrive_mask)) begin
                  state_next = ST_DOOR_OPEN;
                  timer_next = DOOR_LOAD;
                  req_next   = req_next & ~arrive_mask;
               end else if (arrive_floor != F2) begin
                  state_next = ST_IDLE;
               end else begin
                  timer_next = FLOOR_LOAD;
               end
            end
         end

         ST_SOS_HOLD: begin
            req_next = '0;
            if (!sos_sync) begin
               state_next = ST_DOOR_OPEN;
               timer_next = DOOR_LOAD;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign {led3, led2, led1}       = req;
   assign {floor3, floor2, floor1} = floor_onehot(car_floor);
   assign door                     = (state == ST_DOOR_OPEN) || (state == ST_SOS_HOLD);
   assign moving                   = (state == ST_MOVE_UP) || (state == ST_MOVE_DOWN);
   assign sos_mode                 = sos_sync;
   assign weight_limit_exceeded    = overweight;

endmodule

// File: tb/tb_elevator_controller.sv
// Self-checking bench for elevator_controller: directed scenarios plus randomized
// trips and passenger bursts checked against a timing/arithmetic reference model.
module tb_elevator_controller;

   localparam int MAX_PEOPLE  = 6;
   localparam int FLOOR_TICKS = 4;
   localparam int DOOR_TICKS  = 4;
   localparam int BOUND       = 200;
   localparam int SYNC_DELAY  = 3;

   logic clk_50            = 1'b0;
   logic rst_n             = 1'b0;
   logic button1           = 1'b1;
   logic button2           = 1'b1;
   logic button3           = 1'b1;
   logic sos_flip          = 1'b0;
   logic weight_flip       = 1'b0;
   logic weight_flip_reset = 1'b0;
   logic led1, led2, led3;
   logic floor1, floor2, floor3;
   logic door, moving, sos_mode, weight_limit_exceeded;

   int checks    = 0;
   int failures  = 0;
   int cur_floor = 1;

   wire [2:0] leds   = {led3, led2, led1};
   wire [2:0] floors = {floor3, floor2, floor1};

   always #5 clk_50 = ~clk_50;

   elevator_controller #(
      .MAX_PEOPLE  (MAX_PEOPLE),
      .FLOOR_TICKS (FLOOR_TICKS),
      .DOOR_TICKS  (DOOR_TICKS)
   ) dut (
      .clk_50                (clk_50),
      .rst_n                 (rst_n),
      .button1               (button1),
      .button2               (button2),
      .button3               (button3),
      .sos_flip              (sos_flip),
      .weight_flip           (weight_flip),
      .weight_flip_reset     (weight_flip_reset),
      .led1                  (led1),
      .led2                  (led2),
      .led3                  (led3),
      .floor1                (floor1),
      .floor2                (floor2),
      .floor3                (floor3),
      .door                  (door),
      .moving                (moving),
      .sos_mode              (sos_mode),
      .weight_limit_exceeded (weight_limit_exceeded)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] onehot(input int f);
      return 3'(1 << (f - 1));
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk_50);
   endtask

   task automatic press(input int f);
      button1 = (f != 1);
      button2 = (f != 2);
      button3 = (f != 3);
      tick(1);
      button1 = 1'b1;
      button2 = 1'b1;
      button3 = 1'b1;
   endtask

   task automatic pulse_enter();
      weight_flip = 1'b1;
      tick(1);
      weight_flip = 1'b0;
      tick(1);
   endtask

   task automatic pulse_clear();
      weight_flip_reset = 1'b1;
      tick(1);
      weight_flip_reset = 1'b0;
      tick(1);
   endtask

   task automatic wait_quiet(input string tag);
      int n;
      n = 0;
      while (!(door == 1'b0 && moving == 1'b0 && leds == 3'b000) && n < BOUND) begin
         tick(1);
         n++;
      end
      check(tag, 32'(n < BOUND), 1);
   endtask

   // Single call from a quiet car: latch after the sync delay, depart one cycle later,
   // FLOOR_TICKS per floor, then DOOR_TICKS of open door.
   task automatic trip(input int b);
      int d, n, mv, m;
      d = (b > cur_floor) ? (b - cur_floor) : (cur_floor - b);
      press(b);
      tick(SYNC_DELAY - 1);
      if (d == 0) begin
         check("here_door", 32'(door), 1);
      end else begin
         check("call_led", 32'(leds), 32'(onehot(b)));
         check("wait_still", 32'(moving), 0);
         n  = 0;
         mv = 0;
         while (door == 1'b0 && n < BOUND) begin
            tick(1);
            n++;
            if (moving) mv++;
         end
         check("travel_cycles", n, 1 + d * FLOOR_TICKS);
         check("moving_cycles", mv, d * FLOOR_TICKS);
      end
      check("arrive_floor", 32'(floors), 32'(onehot(b)));
      check("arrive_leds", 32'(leds), 0);
      m = 0;
      while (door == 1'b1 && m < BOUND) begin
         tick(1);
         m++;
      end
      check("door_cycles", m, DOOR_TICKS);
      cur_floor = b;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k, sat;

      rst_n = 1'b0;
      tick(2);
      check("rst_floors", 32'(floors), 1);
      check("rst_leds", 32'(leds), 0);
      check("rst_door", 32'(door), 0);
      check("rst_moving", 32'(moving), 0);
      check("rst_sos", 32'(sos_mode), 0);
      check("rst_wle", 32'(weight_limit_exceeded), 0);
      check("rst_count", 32'(dut.count), 0);
      rst_n = 1'b1;
      tick(2);

      trip(3);
      trip(1);
      trip(1);

      // Overweight: door held open, car stays, calls still latch.
      repeat (7) pulse_enter();
      tick(3);
      check("count7", 32'(dut.count), 7);
      check("wle7", 32'(weight_limit_exceeded), 1);
      check("ow_door", 32'(door), 1);
      press(3);
      tick(20);
      check("ow_door_held", 32'(door), 1);
      check("ow_floor", 32'(floors), 1);
      check("ow_led3", 32'(leds), 3'b100);
      check("ow_still", 32'(moving), 0);
      pulse_clear();
      tick(2);
      check("clr_count", 32'(dut.count), 0);
      check("clr_wle", 32'(weight_limit_exceeded), 0);
      check("clr_door", 32'(door), 1);
      n = 0;
      while (!(floors == 3'b100 && door == 1'b1) && n < BOUND) begin
         tick(1);
         n++;
      end
      check("ow_depart", 32'(n < BOUND), 1);
      check("ow_arrive_leds", 32'(leds), 0);
      cur_floor = 3;
      wait_quiet("ow_quiet");
      trip(1);

      // Calls to 3 then 2: intermediate stop at 2 first.
      press(3);
      press(2);
      n = 0;
      while (door == 1'b0 && n < BOUND) begin tick(1); n++; end
      check("two_first_reach", 32'(n < BOUND), 1);
      check("two_first_floor", 32'(floors), 3'b010);
      check("two_first_leds", 32'(leds), 3'b100);
      n = 0;
      while (door == 1'b1 && n < BOUND) begin tick(1); n++; end
      n = 0;
      while (door == 1'b0 && n < BOUND) begin tick(1); n++; end
      check("two_second_reach", 32'(n < BOUND), 1);
      check("two_second_floor", 32'(floors), 3'b100);
      check("two_second_leds", 32'(leds), 0);
      cur_floor = 3;
      wait_quiet("two_quiet");
      trip(1);

      // SOS mid-travel 1 -> 2.
      press(2);
      n = 0;
      while (moving == 1'b0 && n < BOUND) begin tick(1); n++; end
      check("sos_depart", 32'(n < BOUND), 1);
      tick(1);
      sos_flip = 1'b1;
      tick(2);
      check("sos_mode_on", 32'(sos_mode), 1);
      n = 0;
      while (moving == 1'b1 && n < BOUND) begin tick(1); n++; end
      check("sos_floor", 32'(floors), 3'b010);
      check("sos_door", 32'(door), 1);
      check("sos_leds", 32'(leds), 0);
      check("sos_stopped", 32'(moving), 0);
      press(3);
      tick(10);
      check("sos_ignore_leds", 32'(leds), 0);
      check("sos_hold_door", 32'(door), 1);
      check("sos_hold_floor", 32'(floors), 3'b010);
      sos_flip = 1'b0;
      tick(2);
      check("sos_mode_off", 32'(sos_mode), 0);
      check("sos_release_door", 32'(door), 1);
      tick(1 + DOOR_TICKS - 1);
      check("sos_door_last", 32'(door), 1);
      tick(1);
      check("sos_door_closed", 32'(door), 0);
      cur_floor = 2;

      // Saturation and reset-wins-over-enter.
      repeat (17) pulse_enter();
      tick(3);
      check("sat_count", 32'(dut.count), 15);
      check("sat_wle", 32'(weight_limit_exceeded), 1);
      weight_flip       = 1'b1;
      weight_flip_reset = 1'b1;
      tick(1);
      weight_flip       = 1'b0;
      weight_flip_reset = 1'b0;
      tick(3);
      check("both_count", 32'(dut.count), 0);
      check("both_wle", 32'(weight_limit_exceeded), 0);
      wait_quiet("sat_quiet");

      for (int i = 0; i < 8; i++) begin
         trip(int'($urandom_range(3, 1)));
      end

      for (int i = 0; i < 4; i++) begin
         k = int'($urandom_range(20, 0));
         repeat (k) pulse_enter();
         tick(3);
         sat = (k > 15) ? 15 : k;
         check("rand_count", 32'(dut.count), sat);
         check("rand_wle", 32'(weight_limit_exceeded), (sat > MAX_PEOPLE) ? 1 : 0);
         pulse_clear();
         tick(3);
         wait_quiet("rand_w_quiet");
      end

      // Asynchronous reset in the middle of a move.
      k = (cur_floor == 1) ? 3 : 1;
      press(k);
      n = 0;
      while (moving == 1'b0 && n < BOUND) begin tick(1); n++; end
      check("mid_depart", 32'(n < BOUND), 1);
      tick(2);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_floors", 32'(floors), 1);
      check("mid_rst_leds", 32'(leds), 0);
      check("mid_rst_door", 32'(door), 0);
      check("mid_rst_moving", 32'(moving), 0);
      check("mid_rst_sos", 32'(sos_mode), 0);
      check("mid_rst_wle", 32'(weight_limit_exceeded), 0);
      @(negedge clk_50);
      rst_n = 1'b1;
      cur_floor = 1;
      tick(2);
      trip(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
